// File: rtl/sseg_decoder_if.sv
// rtl/sseg_decoder_if.sv - multiplexed seven-segment bus and decoded status bundle
interface sseg_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              SSEG;
  logic [NUM_DIGITS-1:0]   AN;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    update;
  logic                    err;
  logic                    frame_done;

  modport master (
    output SSEG, AN,
    input  digits, valid, blank, update, err, frame_done
  );

  modport slave (
    input  SSEG, AN,
    output digits, valid, blank, update, err, frame_done
  );
endinterface

// File: rtl/sseg_decoder.sv
// rtl/sseg_decoder.sv - samples an active-low multiplexed seven-segment bus and decodes digits
module sseg_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input logic          clk,
  input logic          rst,
  sseg_decoder_if.slave bus
);

  localparam int IN_W = NUM_DIGITS + 7;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_e;

  logic [IN_W-1:0]         sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  state_e                  state_q, state_d;
  logic                    capture;

  logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_nx;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic                    update_q, update_d;
  logic                    err_q, err_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_DIGITS-1:0]   an_s;
  logic [6:0]              seg_s;
  logic                    changed, an_idle, an_onehot;
  logic                    seg_legal, seg_blank;
  logic [3:0]              seg_digit;
  logic [NUM_DIGITS-1:0]   hit;

  // Returns {legal, blank, digit}; blank means all segments dark.
  function automatic logic [5:0] decode(input logic [6:0] s);
    logic [5:0] r;
    r = 6'b000000;
    unique case (s)
      7'b1000000: r = {2'b10, 4'd0};
      7'b1111001: r = {2'b10, 4'd1};
      7'b0100100: r = {2'b10, 4'd2};
      7'b0110000: r = {2'b10, 4'd3};
      7'b0011001: r = {2'b10, 4'd4};
      7'b0010010: r = {2'b10, 4'd5};
      7'b0000010: r = {2'b10, 4'd6};
      7'b1111000: r = {2'b10, 4'd7};
      7'b0000000: r = {2'b10, 4'd8};
      7'b0010000: r = {2'b10, 4'd9};
      7'b1111111: r = {2'b01, 4'hF};
      default:    r = 6'b000000;
    endcase
    return r;
  endfunction

  assign {an_s, seg_s} = sync2_q;
  assign changed   = (sync2_q != prev_q);
  assign an_idle   = &an_s;
  assign an_onehot = $onehot(~an_s);
  assign {seg_legal, seg_blank, seg_digit} = decode(seg_s);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!an_idle) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (changed) begin
          cnt_d   = '0;
          state_d = an_idle ? IDLE : SETTLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        // Stay put while the pattern holds so one stable pattern yields one event.
        if (changed) begin
          cnt_d   = '0;
          state_d = an_idle ? IDLE : SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    digits_d     = digits_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    seen_d       = seen_q;
    seen_nx      = seen_q;
    update_d     = 1'b0;
    err_d        = 1'b0;
    frame_done_d = 1'b0;
    hit          = '0;
    if (capture) begin
      if (!an_onehot) begin
        err_d = 1'b1;
      end else begin
        hit      = ~an_s;
        update_d = seg_legal | seg_blank;
        err_d    = ~(seg_legal | seg_blank);
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (hit[i]) begin
            if (seg_legal || seg_blank) begin
              digits_d[4*i +: 4] = seg_digit;
            end
            valid_d[i] = seg_legal;
            blank_d[i] = seg_blank;
          end
        end
        // Illegal patterns still count toward frame completion.
        seen_nx = seen_q | hit;
        if (&seen_nx) begin
          frame_done_d = 1'b1;
          seen_d       = '0;
        end else begin
          seen_d = seen_nx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      seen_q       <= '0;
      digits_q     <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      update_q     <= 1'b0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      sync1_q      <= {bus.AN, bus.SSEG};
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      seen_q       <= seen_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      update_q     <= update_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digits     = digits_q;
  assign bus.valid      = valid_q;
  assign bus.blank      = blank_q;
  assign bus.update     = update_q;
  assign bus.err        = err_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_sseg_decoder.sv
// tb/tb_sseg_decoder.sv - random and directed bench with a run-length reference model
module tb_sseg_decoder;
  localparam int ND = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sseg_decoder_if #(.NUM_DIGITS(ND)) bus();

  sseg_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic [10:0]     hist [$];
  logic [4*ND-1:0] exp_dig;
  logic [ND-1:0]   exp_val, exp_blk, exp_seen;
  logic            exp_upd, exp_err, exp_fd;
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    exp_dig = '0; exp_val = '0; exp_blk = '0; exp_seen = '0;
    exp_upd = 1'b0; exp_err = 1'b0; exp_fd = 1'b0;
  endtask

  // A pattern is taken exactly when its unbroken run of samples reaches S+1,
  // judged two edges late because of the synchroniser.
  task automatic model_edge();
    int t, j, r, zeros, pos, d;
    logic [10:0] v;
    logic [3:0]  an;
    logic [6:0]  seg;
    exp_upd = 1'b0; exp_err = 1'b0; exp_fd = 1'b0;
    t = hist.size() - 1;
    if (t < 2) return;
    v = hist[t-2];
    r = 0;
    j = t - 2;
    while (j >= 0 && r < S + 2 && hist[j] == v) begin
      r++;
      j--;
    end
    if (r != S + 1) return;
    an  = v[10:7];
    seg = v[6:0];
    if (an == 4'hF) return;
    zeros = ND - $countones(an);
    if (zeros > 1) begin
      exp_err = 1'b1;
      return;
    end
    pos = 0;
    for (int k = 0; k < ND; k++) if (!an[k]) pos = k;
    d = -1;
    for (int k = 0; k < 10; k++) if (pat[k] == seg) d = k;
    if (d >= 0) begin
      exp_dig[4*pos +: 4] = 4'(d);
      exp_val[pos] = 1'b1; exp_blk[pos] = 1'b0; exp_upd = 1'b1;
    end else if (seg == 7'h7F) begin
      exp_dig[4*pos +: 4] = 4'hF;
      exp_val[pos] = 1'b0; exp_blk[pos] = 1'b1; exp_upd = 1'b1;
    end else begin
      exp_val[pos] = 1'b0; exp_blk[pos] = 1'b0; exp_err = 1'b1;
    end
    exp_seen[pos] = 1'b1;
    if (exp_seen == '1) begin
      exp_fd = 1'b1;
      exp_seen = '0;
    end
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg);
    @(negedge clk);
    bus.AN = an;
    bus.SSEG = seg;
    hist.push_back({an, seg});
    @(posedge clk);
    #1;
    model_edge();
    check("update", 32'(bus.update), 32'(exp_upd));
    check("err", 32'(bus.err), 32'(exp_err));
    check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    check("digits", 32'(bus.digits), 32'(exp_dig));
    check("valid", 32'(bus.valid), 32'(exp_val));
    check("blank", 32'(bus.blank), 32'(exp_blk));
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n,
                      output int first_upd, output int n_upd, output int n_err, output int n_fd);
    first_upd = -1; n_upd = 0; n_err = 0; n_fd = 0;
    for (int i = 0; i < n; i++) begin
      step(an, seg);
      if (bus.update) begin
        n_upd++;
        if (first_upd < 0) first_upd = i;
      end
      if (bus.err) n_err++;
      if (bus.frame_done) n_fd++;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, 32'(bus.digits), 32'h0);
    check({tag, "_valid"}, 32'(bus.valid), 32'h0);
    check({tag, "_blank"}, 32'(bus.blank), 32'h0);
    check({tag, "_pulses"}, 32'({bus.update, bus.err, bus.frame_done}), 32'h0);
  endtask

  initial begin
    int fu, nu, ne, nf, su, se, sf, hl;
    logic [3:0] an;
    logic [6:0] seg;
    bus.AN = 4'hF;
    bus.SSEG = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    hold(4'hF, 7'h7F, 3, fu, nu, ne, nf);
    hold(4'b1110, 7'b0110000, 10, fu, nu, ne, nf);
    check("t1_first_upd", 32'(fu), 32'(2 + S));
    check("t1_n_upd", 32'(nu), 32'd1);
    check("t1_n_err", 32'(ne), 32'd0);
    check("t1_digit", 32'(bus.digits[3:0]), 32'h3);
    check("t1_valid", 32'(bus.valid), 32'b0001);

    su = 0; sf = 0;
    hold(4'b1110, 7'b1000000, 8, fu, nu, ne, nf); su += nu; sf += nf;
    hold(4'b1101, 7'b1111001, 8, fu, nu, ne, nf); su += nu; sf += nf;
    hold(4'b1011, 7'b0100100, 8, fu, nu, ne, nf); su += nu; sf += nf;
    hold(4'b0111, 7'b1111000, 8, fu, nu, ne, nf); su += nu; sf += nf;
    check("t2_fd_on_last", 32'(nf), 32'd1);
    check("t2_n_fd", 32'(sf), 32'd1);
    check("t2_n_upd", 32'(su), 32'd4);
    check("t2_digits", 32'(bus.digits), 32'h7210);
    check("t2_valid", 32'(bus.valid), 32'hF);

    hold(4'b1101, 7'b0010010, 3, fu, nu, ne, nf); su = nu;
    hold(4'b1101, 7'b0000010, 8, fu, nu, ne, nf); su += nu;
    check("t3_n_upd", 32'(su), 32'd1);
    check("t3_digit", 32'(bus.digits[7:4]), 32'h6);

    hold(4'b1110, 7'b1111111, 8, fu, nu, ne, nf);
    check("t4_blank_digit", 32'(bus.digits[3:0]), 32'hF);
    check("t4_blank", 32'(bus.blank[0]), 32'd1);
    check("t4_blank_valid", 32'(bus.valid[0]), 32'd0);
    hold(4'b1110, 7'b0101010, 8, fu, nu, ne, nf);
    check("t4_n_err", 32'(ne), 32'd1);
    check("t4_n_upd", 32'(nu), 32'd0);
    check("t4_ill_blank", 32'(bus.blank[0]), 32'd0);
    check("t4_ill_digit", 32'(bus.digits[3:0]), 32'hF);

    hold(4'b1100, 7'b0000000, 8, fu, nu, ne, nf);
    check("t5_n_err", 32'(ne), 32'd1);
    check("t5_n_upd", 32'(nu), 32'd0);
    check("t5_digits", 32'(bus.digits), 32'h726F);
    check("t5_valid", 32'(bus.valid), 32'b1110);
    check("t5_blank", 32'(bus.blank), 32'b0000);

    hold(4'b1011, 7'b0011001, 3, fu, nu, ne, nf);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("t6_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    hold(4'b1011, 7'b0011001, 10, fu, nu, ne, nf);
    check("t6_first_upd", 32'(fu), 32'(2 + S));
    check("t6_n_upd", 32'(nu), 32'd1);
    check("t6_digits", 32'(bus.digits), 32'h0400);
    check("t6_valid", 32'(bus.valid), 32'b0100);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       an = 4'hF;
        1:       an = 4'($urandom);
        default: an = ~(4'b0001 << $urandom_range(0, ND - 1));
      endcase
      case ($urandom_range(0, 5))
        0, 1, 2: seg = pat[$urandom_range(0, 9)];
        3:       seg = 7'h7F;
        default: seg = 7'($urandom);
      endcase
      if (an == 4'h0 && seg == 7'h00) seg = 7'h7F;
      hl = $urandom_range(1, 9);
      hold(an, seg, hl, fu, nu, ne, nf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sseg_decoder.md
Name: sseg_decoder

Overview:
Receive-side counterpart of the seven-segment encoder. It samples a multiplexed, active-low seven-segment bus (segments plus one-hot active-low anodes) and waits for each pattern to hold stable. It then decodes the pattern back to a 4-bit BCD digit per anode position and flags blanks and illegal patterns. It serves as a loopback checker and display monitor in self-test builds and drives status LEDs and the UART debug path.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (1..8)
STABLE_CYCLES, 4, consecutive synchronised cycles {AN,SSEG} must hold before capture (>=1)
CNT_W, 8, stability counter width; STABLE_CYCLES must be < 2**CNT_W

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
SSEG  in  7  segment lines, active-low, bit0=a .. bit6=g
AN  in  NUM_DIGITS  anode selects, active-low, at most one low
digits  out  4*NUM_DIGITS  captured BCD per position, position i at [4i+3:4i]
valid  out  NUM_DIGITS  position holds a legal decimal pattern
blank  out  NUM_DIGITS  position last captured as all-segments-off
update  out  1  one-cycle pulse on any capture
err  out  1  one-cycle pulse on illegal segment pattern or non-one-hot anode
frame_done  out  1  one-cycle pulse when every position has been captured since the last frame_done

Behaviour:
- Reset is asynchronous and active-high: clk, rst; the reset polarity and synchronicity are fixed.
- Reset values:
  - digits=0, valid=0, blank=0, update=0, err=0, frame_done=0.
  - Synchronisers and stability counter cleared; state IDLE; seen mask 0.
- Input path:
  - Two-flop synchroniser on the full {AN,SSEG} vector.
  - A previous-value register feeds the change detector.
- FSM states:
  - IDLE: synced AN all ones (no digit driven). No captures.
  - SETTLE: counter increments each cycle the synced value equals the previous one. Any change clears the counter and re-enters SETTLE, or enters IDLE if AN is all ones.
  - HELD: entered when the counter reaches STABLE_CYCLES-1 with the value unchanged. Exactly one capture or err event occurs on entry. The block stays in HELD until the synced value changes, so there is no repeat capture.
- Latency: if pins are constant from edge k, outputs and pulses update at edge k+2+STABLE_CYCLES. A change before then restarts the count with no capture.
- Decode table (SSEG -> digit):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4
  - 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9
- Capture on a legal pattern at the one-hot position i: digits[i] is written, valid[i]=1, blank[i]=0, update=1.
- Capture of 1111111: digits[i]=4'hF, valid[i]=0, blank[i]=1, update=1.
- Any other pattern: err=1, update=0, digits[i] unchanged, valid[i]=0, blank[i]=0.
- AN with two or more bits low on entry to HELD: err=1, no position modified.
- seen mask:
  - Bit i is set on any capture or illegal-pattern event at position i.
  - When all bits are set, frame_done pulses on the same edge as that event and the mask clears.
  - Repeat captures of one position within a frame are allowed.
- Reset asserted mid-SETTLE or in HELD returns everything to reset values immediately. The first capture after release needs the full 2+STABLE_CYCLES.
- update and err are mutually exclusive. frame_done can coincide with either.

Test Plan:
1. Reset, then AN=4'b1110, SSEG=7'b0110000 held 10 cycles -> digits[3:0]=3, valid=0001, single update pulse exactly at edge 2+4 after the change, err=0.
2. Drive a full scan: AN 1110/1101/1011/0111 with 0,1,2,7 patterns, each held 8 cycles -> digits=16'h7210, valid=1111, frame_done pulses once on the fourth capture.
3. Glitch: pattern for 5 held only 3 cycles, then 6 held 8 cycles on AN=1101 -> no capture of 5, digits[7:4]=6, one update pulse.
4. AN=1110, SSEG=7'b1111111 -> digits[3:0]=F, blank[0]=1, valid[0]=0. Then SSEG=7'b0101010 -> one err pulse, blank[0]=0, valid[0]=0, digits[3:0] remains F.
5. AN=1100 with SSEG=7'b0000000 held 8 cycles -> one err pulse, digits/valid/blank unchanged, no update.
6. Assert rst during SETTLE (cycle 3 of the count) -> all outputs 0 immediately. After release, an unchanged input captures at 2+STABLE_CYCLES edges.
